i2c_txn_sequencer: RTL and testbench



---
 rtl/i2c_txn_sequencer_if.sv | 45 ++++
 rtl/i2c_txn_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_i2c_txn_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_txn_sequencer_if.sv
// Request/response and byte-controller command bundle for i2c_txn_sequencer.
// Latency: none. This file holds wiring only.
// Backpressure: req_valid_i/req_ready_o handshake. Each byte command is held until cmd_done_i.
interface i2c_txn_sequencer_if #(
  parameter int MAX_BYTES = 4
);
  localparam int LW = $clog2(MAX_BYTES);

  logic                   req_valid_i;
  logic                   req_ready_o;
  logic                   req_rnw_i;
  logic [6:0]             req_dev_i;
  logic [7:0]             req_reg_i;
  logic [LW-1:0]          req_len_i;
  logic [8*MAX_BYTES-1:0] req_wdata_i;
  logic                   rsp_valid_o;
  logic [1:0]             rsp_err_o;
  logic [8*MAX_BYTES-1:0] rsp_rdata_o;
  logic                   cmd_start_o;
  logic                   cmd_stop_o;
  logic                   cmd_read_o;
  logic                   cmd_write_o;
  logic                   cmd_ack_o;
  logic [7:0]             cmd_din_o;
  logic                   cmd_done_i;
  logic                   cmd_rxack_i;
  logic [7:0]             cmd_dout_i;
  logic                   cmd_al_i;

  // Sequencer view.
  modport master (
    input  req_valid_i, req_rnw_i, req_dev_i, req_reg_i, req_len_i, req_wdata_i,
    input  cmd_done_i, cmd_rxack_i, cmd_dout_i, cmd_al_i,
    output req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
    output cmd_start_o, cmd_stop_o, cmd_read_o, cmd_write_o, cmd_ack_o, cmd_din_o
  );

  // Requester plus byte-controller view.
  modport slave (
    output req_valid_i, req_rnw_i, req_dev_i, req_reg_i, req_len_i, req_wdata_i,
    output cmd_done_i, cmd_rxack_i, cmd_dout_i, cmd_al_i,
    input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
    input  cmd_start_o, cmd_stop_o, cmd_read_o, cmd_write_o, cmd_ack_o, cmd_din_o
  );
endinterface

// File: rtl/i2c_txn_sequencer.sv
// Turns one I2C register request into START/WRITE/rSTART/READ/STOP byte commands. Optional watchdog: I2C_SEQ_TIMEOUT_EN.
// Latency: first command 1 cycle after accept; one idle GAP cycle after each done; rsp_valid_o 1 cycle after the final done.
// Backpressure: req_ready_o only in IDLE. Each command is held until cmd_done_i. cmd_al_i (or the watchdog) aborts to RESP.
module i2c_txn_sequencer #(
  parameter int          MAX_BYTES      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                HCLK,
  input  logic                HRESET,
  i2c_txn_sequencer_if.master bus
);
  localparam int LW = $clog2(MAX_BYTES);

  typedef enum logic [3:0] {
    S_IDLE, S_DEVW, S_REG, S_RSTART, S_WDATA, S_RDATA, S_STOP, S_GAP, S_RESP
  } state_t;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       read;
    logic       write;
    logic       ack;
    logic [7:0] din;
  } cmd_t;

  state_t                 r_state;
  state_t                 r_next;    // command to issue when leaving GAP
  cmd_t                   r_cmd;
  logic                   r_rnw;
  logic [6:0]             r_dev;
  logic [7:0]             r_reg;
  logic [LW-1:0]          r_len;
  logic [LW-1:0]          r_idx;
  logic [8*MAX_BYTES-1:0] r_wdata;
  logic [8*MAX_BYTES-1:0] r_rdata;
  logic                   r_req_rdy;
  logic                   r_rsp_vld;
  logic [1:0]             r_err;

  logic                   w_last;
  logic                   w_pending;
  logic                   w_to_hit;
  logic [7:0]             w_wbyte;

  function automatic cmd_t mk_cmd(input logic s, input logic p, input logic r,
                                  input logic w, input logic a, input logic [7:0] d);
    return {s, p, r, w, a, d};
  endfunction

  assign w_last    = (r_idx == r_len);
  assign w_pending = (r_state == S_DEVW) || (r_state == S_REG) || (r_state == S_RSTART) ||
                     (r_state == S_WDATA) || (r_state == S_RDATA) || (r_state == S_STOP);
  assign w_wbyte   = r_wdata[{r_idx, 3'b000} +: 8];

`ifdef I2C_SEQ_TIMEOUT_EN
  logic [31:0] r_wdog;

  // Watchdog: held at zero outside pending states, so it restarts with each issued command.
  always_ff @(posedge HCLK) begin
    if (HRESET || !w_pending) r_wdog <= '0;
    else                      r_wdog <= r_wdog + 32'd1;
  end

  assign w_to_hit = w_pending && (r_wdog == TIMEOUT_CYCLES);
`else
  // The watchdog is absent. The term only keeps the parameter referenced.
  assign w_to_hit = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  // Transaction FSM. Every output is registered here.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state   <= S_IDLE;
      r_next    <= S_IDLE;
      r_cmd     <= '0;
      r_rnw     <= 1'b0;
      r_dev     <= '0;
      r_reg     <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_req_rdy <= 1'b1;
      r_rsp_vld <= 1'b0;
      r_err     <= 2'b00;
    end else begin
      r_rsp_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid_i && r_req_rdy) begin
            r_rnw     <= bus.req_rnw_i;
            r_dev     <= bus.req_dev_i;
            r_reg     <= bus.req_reg_i;
            r_len     <= bus.req_len_i;
            r_wdata   <= bus.req_wdata_i;
            r_rdata   <= '0;
            r_idx     <= '0;
            r_err     <= 2'b00;
            r_req_rdy <= 1'b0;
            r_cmd     <= mk_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {bus.req_dev_i, 1'b0});
            r_state   <= S_DEVW;
          end
        end
        S_GAP: begin
          if (bus.cmd_al_i) begin
            r_err     <= 2'b10;
            r_rsp_vld <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_state <= r_next;
            case (r_next)
              S_REG:    r_cmd <= mk_cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, r_reg);
              S_RSTART: r_cmd <= mk_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {r_dev, 1'b1});
              S_WDATA:  r_cmd <= mk_cmd(1'b0, w_last, 1'b0, 1'b1, 1'b0, w_wbyte);
              S_RDATA:  r_cmd <= mk_cmd(1'b0, w_last, 1'b1, 1'b0, w_last, 8'h00);
              default:  r_cmd <= mk_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            endcase
          end
        end
        S_RESP: begin
          r_req_rdy <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: begin
          // A command is outstanding. Arbitration loss beats done, and done beats the watchdog.
          if (bus.cmd_al_i) begin
            r_cmd     <= '0;
            r_err     <= 2'b10;
            r_rsp_vld <= 1'b1;
            r_state   <= S_RESP;
          end else if (bus.cmd_done_i) begin
            r_cmd <= '0;
            if (bus.cmd_rxack_i && (r_state != S_RDATA) && (r_state != S_STOP)) begin
              r_err <= 2'b01;
              if (r_cmd.stop) begin
                r_rsp_vld <= 1'b1;
                r_state   <= S_RESP;
              end else begin
                r_next  <= S_STOP;
                r_state <= S_GAP;
              end
            end else begin
              case (r_state)
                S_DEVW: begin
                  r_next  <= S_REG;
                  r_state <= S_GAP;
                end
                S_REG: begin
                  r_next  <= r_rnw ? S_RSTART : S_WDATA;
                  r_state <= S_GAP;
                end
                S_RSTART: begin
                  r_next  <= S_RDATA;
                  r_state <= S_GAP;
                end
                S_WDATA, S_RDATA: begin
                  if (r_state == S_RDATA) r_rdata[{r_idx, 3'b000} +: 8] <= bus.cmd_dout_i;
                  if (w_last) begin
                    r_rsp_vld <= 1'b1;
                    r_state   <= S_RESP;
                  end else begin
                    r_idx   <= r_idx + 1'b1;
                    r_next  <= r_state;
                    r_state <= S_GAP;
                  end
                end
                default: begin
                  r_rsp_vld <= 1'b1;
                  r_state   <= S_RESP;
                end
              endcase
            end
          end else if (w_to_hit) begin
            r_cmd     <= '0;
            r_err     <= 2'b11;
            r_rsp_vld <= 1'b1;
            r_state   <= S_RESP;
          end
        end
      endcase
    end
  end

  assign bus.req_ready_o = r_req_rdy;
  assign bus.rsp_valid_o = r_rsp_vld;
  assign bus.rsp_err_o   = r_err;
  assign bus.rsp_rdata_o = r_rdata;
  assign bus.cmd_start_o = r_cmd.start;
  assign bus.cmd_stop_o  = r_cmd.stop;
  assign bus.cmd_read_o  = r_cmd.read;
  assign bus.cmd_write_o = r_cmd.write;
  assign bus.cmd_ack_o   = r_cmd.ack;
  assign bus.cmd_din_o   = r_cmd.din;
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: directed table, random transactions against a command-list model, reset and watchdog cases.
// Latency: checks the exact cycle of each command, each GAP and each response.
// Backpressure: acts as the byte controller and returns done after 0..2 extra hold cycles.
module tb_i2c_txn_sequencer;
  typedef struct packed {
    logic       start;
    logic       stop;
    logic       read;
    logic       write;
    logic       ack;
    logic [7:0] din;
  } cmd_t;

  typedef struct {
    logic        rnw;
    logic [6:0]  dev;
    logic [7:0]  rg;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic [31:0] rbytes;
    int          nack_idx;
    int          al_idx;
    int          rst_idx;
  } txn_t;

  typedef struct {
    txn_t        t;
    logic [1:0]  exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    cmd_t       c;
    logic       rx;
    logic       al;
    logic [7:0] dout;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  step_t       steps[$];
  logic [1:0]  m_err;
  logic [31:0] m_rdata;

  i2c_txn_sequencer_if #(.MAX_BYTES(4)) bus();

  i2c_txn_sequencer #(.MAX_BYTES(4), .TIMEOUT_CYCLES(16)) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1, "bench time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk(input logic s, input logic p, input logic r,
                              input logic w, input logic a, input logic [7:0] d);
    return {s, p, r, w, a, d};
  endfunction

  function automatic cmd_t cmd_now();
    return {bus.cmd_start_o, bus.cmd_stop_o, bus.cmd_read_o, bus.cmd_write_o,
            bus.cmd_ack_o, bus.cmd_din_o};
  endfunction

  function automatic txn_t mk_txn(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                                  input logic [1:0] len, input logic [31:0] wdata,
                                  input logic [31:0] rbytes, input int nack_idx,
                                  input int al_idx, input int rst_idx);
    txn_t t;
    t.rnw = rnw; t.dev = dev; t.rg = rg; t.len = len; t.wdata = wdata; t.rbytes = rbytes;
    t.nack_idx = nack_idx; t.al_idx = al_idx; t.rst_idx = rst_idx;
    return t;
  endfunction

  // Reference model: the full command list from the protocol rules. It is cut at the first
  // arbitration loss or address/write NACK, and a STOP-only command is appended after a NACK
  // when the NACKed command did not itself carry STOP.
  function automatic void build(input txn_t t);
    cmd_t  full[$];
    step_t s;
    int    k;
    full.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {t.dev, 1'b0}));
    full.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t.rg));
    if (t.rnw) begin
      full.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {t.dev, 1'b1}));
      for (int j = 0; j <= int'(t.len); j++)
        full.push_back(mk(1'b0, j == int'(t.len), 1'b1, 1'b0, j == int'(t.len), 8'h00));
    end else begin
      for (int j = 0; j <= int'(t.len); j++)
        full.push_back(mk(1'b0, j == int'(t.len), 1'b0, 1'b1, 1'b0, t.wdata[8*j +: 8]));
    end
    steps.delete();
    m_err   = 2'b00;
    m_rdata = '0;
    for (int i = 0; i < full.size(); i++) begin
      s.c    = full[i];
      s.al   = (i == t.al_idx);
      s.rx   = full[i].read ? 1'($urandom) : (i == t.nack_idx);
      s.dout = 8'($urandom);
      k      = i - 3;
      if (full[i].read) s.dout = t.rbytes[8*k +: 8];
      steps.push_back(s);
      if (s.al) begin
        m_err = 2'b10;
        break;
      end
      if (full[i].read) begin
        m_rdata[8*k +: 8] = s.dout;
      end else if (s.rx) begin
        m_err = 2'b01;
        if (!full[i].stop) begin
          s.c = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
          s.rx = 1'b0; s.al = 1'b0; s.dout = 8'h00;
          steps.push_back(s);
        end
        break;
      end
    end
  endfunction

  task automatic run_txn(input string tag, input txn_t t, input logic use_tbl,
                         input logic [1:0] exp_err, input logic [31:0] exp_rdata);
    cmd_t        act;
    int          d;
    logic [1:0]  e_err;
    logic [31:0] e_rdata;
    build(t);
    e_err   = use_tbl ? exp_err : m_err;
    e_rdata = use_tbl ? exp_rdata : m_rdata;
    check({tag, " ready_idle"}, 64'(bus.req_ready_o), 64'd1);
    bus.req_valid_i = 1'b1;
    bus.req_rnw_i   = t.rnw;
    bus.req_dev_i   = t.dev;
    bus.req_reg_i   = t.rg;
    bus.req_len_i   = t.len;
    bus.req_wdata_i = t.wdata;
    tick();
    bus.req_valid_i = 1'b0;
    bus.req_rnw_i   = 1'($urandom);
    bus.req_dev_i   = 7'($urandom);
    bus.req_reg_i   = 8'($urandom);
    bus.req_len_i   = 2'($urandom);
    bus.req_wdata_i = $urandom;
    for (int i = 0; i < steps.size(); i++) begin
      if (i == 0) check({tag, " ready_busy"}, 64'(bus.req_ready_o), 64'd0);
      act = cmd_now();
      if (!steps[i].c.write) act.din = 8'h00;
      check($sformatf("%s cmd%0d", tag, i), 64'(act), 64'(steps[i].c));
      if (i == t.rst_idx) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check({tag, " rst_cmd"}, 64'(cmd_now()), 64'd0);
        check({tag, " rst_ready"}, 64'(bus.req_ready_o), 64'd1);
        check({tag, " rst_rsp"}, 64'(bus.rsp_valid_o), 64'd0);
        check({tag, " rst_err"}, 64'(bus.rsp_err_o), 64'd0);
        check({tag, " rst_rdata"}, 64'(bus.rsp_rdata_o), 64'd0);
        return;
      end
      d = $urandom_range(0, 2);
      if (d > 0) begin
        repeat (d) tick();
        act = cmd_now();
        if (!steps[i].c.write) act.din = 8'h00;
        check($sformatf("%s hold%0d", tag, i), 64'(act), 64'(steps[i].c));
      end
      bus.cmd_done_i  = 1'b1;
      bus.cmd_rxack_i = steps[i].rx;
      bus.cmd_dout_i  = steps[i].dout;
      bus.cmd_al_i    = steps[i].al;
      tick();
      bus.cmd_done_i  = 1'b0;
      bus.cmd_rxack_i = 1'b0;
      bus.cmd_al_i    = 1'b0;
      bus.cmd_dout_i  = 8'($urandom);
      if (i != steps.size() - 1) begin
        check($sformatf("%s gap%0d", tag, i), 64'(cmd_now()), 64'd0);
        check($sformatf("%s rsp_early%0d", tag, i), 64'(bus.rsp_valid_o), 64'd0);
        tick();
      end
    end
    check({tag, " end_cmd"}, 64'(cmd_now()), 64'd0);
    check({tag, " rsp_valid"}, 64'(bus.rsp_valid_o), 64'd1);
    check({tag, " rsp_err"}, 64'(bus.rsp_err_o), 64'(e_err));
    check({tag, " rsp_rdata"}, 64'(bus.rsp_rdata_o), 64'(e_rdata));
    tick();
    check({tag, " rsp_pulse"}, 64'(bus.rsp_valid_o), 64'd0);
    check({tag, " ready_back"}, 64'(bus.req_ready_o), 64'd1);
    check({tag, " err_hold"}, 64'(bus.rsp_err_o), 64'(e_err));
  endtask

  vec_t vecs[10];

  initial begin
    int seen;
    bus.req_valid_i = 1'b0; bus.req_rnw_i = 1'b0; bus.req_dev_i = '0; bus.req_reg_i = '0;
    bus.req_len_i = '0; bus.req_wdata_i = '0;
    bus.cmd_done_i = 1'b0; bus.cmd_rxack_i = 1'b0; bus.cmd_dout_i = '0; bus.cmd_al_i = 1'b0;

    vecs[0] = '{mk_txn(1'b0, 7'h50, 8'h10, 2'd1, 32'h0000_3CA5, 32'h0, -1, -1, -1), 2'd0, 32'h0};
    vecs[1] = '{mk_txn(1'b1, 7'h50, 8'h02, 2'd2, 32'h0, 32'h0033_2211, -1, -1, -1), 2'd0, 32'h0033_2211};
    vecs[2] = '{mk_txn(1'b0, 7'h2A, 8'h33, 2'd1, 32'h0000_1234, 32'h0, 1, -1, -1), 2'd1, 32'h0};
    vecs[3] = '{mk_txn(1'b1, 7'h50, 8'h07, 2'd1, 32'h0, 32'h0000_BBAA, -1, 2, -1), 2'd2, 32'h0};
    vecs[4] = '{mk_txn(1'b0, 7'h7F, 8'hFF, 2'd0, 32'h0000_00C3, 32'h0, 2, -1, -1), 2'd1, 32'h0};
    vecs[5] = '{mk_txn(1'b1, 7'h01, 8'h80, 2'd3, 32'h0, 32'hDEAD_BEEF, -1, -1, -1), 2'd0, 32'hDEAD_BEEF};
    vecs[6] = '{mk_txn(1'b1, 7'h3C, 8'h44, 2'd0, 32'h0, 32'h0000_0099, 0, -1, -1), 2'd1, 32'h0};
    vecs[7] = '{mk_txn(1'b1, 7'h22, 8'h55, 2'd1, 32'h0, 32'h0000_7766, -1, 4, -1), 2'd2, 32'h0000_0066};
    vecs[8] = '{mk_txn(1'b1, 7'h50, 8'h01, 2'd1, 32'h0, 32'h0000_1111, -1, -1, 3), 2'd0, 32'h0};
    vecs[9] = '{mk_txn(1'b0, 7'h50, 8'h20, 2'd3, 32'h89AB_CDEF, 32'h0, -1, -1, -1), 2'd0, 32'h0};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("reset ready", 64'(bus.req_ready_o), 64'd1);
    check("reset rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("reset err", 64'(bus.rsp_err_o), 64'd0);
    check("reset rdata", 64'(bus.rsp_rdata_o), 64'd0);
    check("reset cmd", 64'(cmd_now()), 64'd0);

    for (int v = 0; v < 10; v++)
      run_txn($sformatf("vec%0d", v), vecs[v].t, 1'b1, vecs[v].exp_err, vecs[v].exp_rdata);

    for (int n = 0; n < 40; n++) begin
      txn_t t;
      int   nc;
      t.rnw    = 1'($urandom);
      t.dev    = 7'($urandom);
      t.rg     = 8'($urandom);
      t.len    = 2'($urandom);
      t.wdata  = $urandom;
      t.rbytes = $urandom;
      nc       = t.rnw ? 4 + int'(t.len) : 3 + int'(t.len);
      t.nack_idx = ($urandom_range(0, 9) < 3) ?
                   (t.rnw ? int'($urandom_range(0, 2)) : int'($urandom_range(0, nc - 1))) : -1;
      t.al_idx   = ($urandom_range(0, 9) < 2) ? int'($urandom_range(0, nc - 1)) : -1;
      t.rst_idx  = -1;
      run_txn($sformatf("rnd%0d", n), t, 1'b0, 2'b00, 32'h0);
    end

    // Byte controller never answers.
    bus.req_valid_i = 1'b1; bus.req_rnw_i = 1'b0; bus.req_dev_i = 7'h11;
    bus.req_reg_i = 8'h22; bus.req_len_i = 2'd0; bus.req_wdata_i = 32'h33;
    tick();
    bus.req_valid_i = 1'b0;
    check("wdog issue", 64'(cmd_now()), 64'(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22)));
`ifdef I2C_SEQ_TIMEOUT_EN
    repeat (16) tick();
    check("wdog not_yet", 64'(bus.rsp_valid_o), 64'd0);
    check("wdog held", 64'(cmd_now()), 64'(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22)));
    tick();
    check("wdog rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    check("wdog err", 64'(bus.rsp_err_o), 64'd3);
    check("wdog cmd_low", 64'(cmd_now()), 64'd0);
    tick();
    check("wdog ready", 64'(bus.req_ready_o), 64'd1);
`else
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.rsp_valid_o) seen++;
    end
    check("nowdog no_rsp", 64'(seen), 64'd0);
    check("nowdog held", 64'(cmd_now()), 64'(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("nowdog rst_ready", 64'(bus.req_ready_o), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
